spi_cmd_decoder: RTL and testbench
==================================

# spi_cmd_decoder

Parametrised SPI command decoder and register file for the delay signal generator. Sits between the SPI byte deserializer and the delay channels. Frames bytes under `spi_cs`, decodes read/write commands with auto-incrementing burst addressing, and holds `NUM_REGS` channel delay registers of `REG_W` bits. Returns read data byte-by-byte to the SPI serializer.

## Interface
Parameters:
- `NUM_REGS`, 16: number of delay registers; 2..128.
- `REG_W`, 16: register width; a multiple of 8, from 8 to 32.
- `ID_BYTE`, 8'hA5: byte presented on `tx_data` while idle.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `spi_cs`  in  1  active-low frame select; high = deselected.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a complete received byte.
- `rx_data`  in  8  received byte.
- `tx_data`  out  8  byte the serializer shifts out for the next byte slot.
- `regs`  out  NUM_REGS*REG_W  flattened register file; reg k at `[k*REG_W +: REG_W]`.
- `wr_strobe`  out  1  one-cycle pulse when a register commits.
- `wr_addr`  out  $clog2(NUM_REGS)  index of the committed register; valid with `wr_strobe`.
- `cmd_err`  out  1  one-cycle pulse on an out-of-range command address.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- Command byte: bit7 = 1 write / 0 read; bits[6:0] = start address. An address ≥ NUM_REGS is an error.
- Data phase: NB = REG_W/8 bytes per register, MSB first. After each complete register, the address increments and wraps from NUM_REGS-1 to 0. Bursts are unlimited until `spi_cs` goes high.
- States:
  - IDLE: `tx_data`=ID_BYTE. Goes to CMD when `spi_cs`=0.
  - CMD: on `rx_valid`, latch the address and clear the byte counter. Go to WDATA (write, in range), RDATA (read, in range), or DISCARD (out of range; pulse `cmd_err`).
  - WDATA: each `rx_valid` shifts `rx_data` into the assembly register and increments the byte counter. On byte NB, commit to `regs[addr]`, pulse `wr_strobe` with the current `wr_addr`, and advance the address.
  - RDATA: each `rx_valid` advances the byte pointer and loads the next `tx_data` byte. After byte NB, reload from the incremented address. `regs` are unchanged.
  - DISCARD: ignore all bytes; `tx_data`=8'h00.
- `spi_cs`=1 in any non-IDLE state forces IDLE on the next edge.
  - A partially assembled write is dropped with no commit.
  - The byte counter and assembly register clear.
- `spi_cs`=1 together with `rx_valid` in the same cycle: `cs` wins and the byte is ignored.
- `rx_valid` while in IDLE is ignored.
- NUM_REGS not a power of two: the address wraps explicitly at NUM_REGS-1, never at 2^ADDR_W.

## Timing
- Reset values:
  - `regs`=0, `tx_data`=ID_BYTE.
  - `wr_strobe`, `cmd_err`, `busy` = 0.
  - `wr_addr`=0, state=IDLE.
- IDLE→CMD: `busy` rises one cycle after `spi_cs` falls.
- Write commit: `regs` updates at the edge that samples the NB-th `rx_valid`. It is visible, and `wr_strobe` is high, the following cycle.
- `cmd_err` is high the cycle after the command byte's `rx_valid`.
- Read data:
  - `tx_data` holds the MSB of `regs[addr]` the cycle after the command byte's `rx_valid`.
  - Each later byte appears the cycle after the previous `rx_valid`.
  - The serializer has at least one full byte time, so there is no back-to-back constraint.
- Back-to-back `rx_valid` on consecutive cycles must be accepted in every state.
- `reset` mid-frame overrides everything and stays in IDLE regardless of `spi_cs`, until `spi_cs` is seen low after reset deasserts.

## Structure
- Package `spi_cmd_pkg`: state enum (IDLE, CMD, WDATA, RDATA, DISCARD), the `CMD_WRITE_BIT`=7 constant, and the ADDR_W helper function.
- One sub-module, `spi_reg_bank`: register storage with write port (en, addr, data) and a read mux returning the full word for `addr`. The FSM, byte counter and assembly register stay in `spi_cmd_decoder`.

## Test plan
Configuration for all scenarios is NUM_REGS=16, REG_W=16.
- Write single register: frame 0x83, 0x12, 0x34 → `regs[3]`=16'h1234; one `wr_strobe` with `wr_addr`=3; all other regs stay 0.
- Burst write with wrap: 0x8F, 0xAA, 0xBB, 0xCC, 0xDD → `regs[15]`=16'hAABB, `regs[0]`=16'hCCDD; two strobes with addresses 15 then 0.
- Burst read: preload `regs[2]`=16'hBEEF and `regs[3]`=16'h0102, then send 0x02 plus four dummy bytes → `tx_data` sequence 0xBE, 0xEF, 0x01, 0x02; `regs` unchanged.
- Out-of-range address: 0x90, 0x55, 0x66 → `cmd_err` pulses once; no `wr_strobe`; `tx_data`=0x00 until `cs` rises, then ID_BYTE=0xA5.
- Abort mid-write: 0x85, 0x77, then `spi_cs` high (including one case where `cs` rises in the same cycle as a `rx_valid`) → `regs[5]` unchanged, state IDLE, `busy`=0 the next cycle.
- Reset mid-burst: assert `reset` during WDATA → all `regs`=0, `tx_data`=0xA5, outputs at reset values the next cycle.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// ============================================================================
// spi_cmd_pkg : shared types and constants for the SPI command decoder
// Revision    : 1.0
// ============================================================================
`default_nettype none

package spi_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WDATA   = 3'd2,
    ST_RDATA   = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  localparam int CMD_WRITE_BIT = 7;

  function automatic int addr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cmd_decoder_if.sv
// ============================================================================
// spi_cmd_decoder_if : byte stream in / register file and status out
// Revision           : 1.0
// ============================================================================
`default_nettype none

interface spi_cmd_decoder_if
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 16
);
  localparam int ADDR_W = addr_w(NUM_REGS);

  logic                      spi_cs;
  logic                      rx_valid;
  logic [7:0]                rx_data;
  logic [7:0]                tx_data;
  logic [NUM_REGS*REG_W-1:0] regs;
  logic                      wr_strobe;
  logic [ADDR_W-1:0]         wr_addr;
  logic                      cmd_err;
  logic                      busy;

  modport master (
    output spi_cs, rx_valid, rx_data,
    input  tx_data, regs, wr_strobe, wr_addr, cmd_err, busy
  );

  modport slave (
    input  spi_cs, rx_valid, rx_data,
    output tx_data, regs, wr_strobe, wr_addr, cmd_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/spi_reg_bank.sv
// ============================================================================
// spi_reg_bank : delay register storage with one write port and a word read mux
// Revision     : 1.0
// ============================================================================
`default_nettype none

module spi_reg_bank
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 16,
  localparam int AW      = addr_w(NUM_REGS)
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      wr_en,
  input  wire logic [AW-1:0]             wr_addr,
  input  wire logic [REG_W-1:0]          wr_data,
  input  wire logic [AW-1:0]             rd_addr,
  output logic      [REG_W-1:0]          rd_data,
  output logic      [NUM_REGS*REG_W-1:0] regs_flat
);

  logic [REG_W-1:0] mem_q [NUM_REGS];
  logic [REG_W-1:0] mem_d [NUM_REGS];

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      mem_d[k] = mem_q[k];
    end
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REGS; k++) begin
      if (reset) begin
        mem_q[k] <= '0;
      end else begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*REG_W +: REG_W] = mem_q[g];
  end

endmodule

`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
// ============================================================================
// spi_cmd_decoder : SPI read/write command FSM with burst addressing
// Revision        : 1.0
// ============================================================================
`default_nettype none

module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter int         REG_W    = 16,
  parameter logic [7:0] ID_BYTE  = 8'hA5
) (
  input wire logic        clk,
  input wire logic        reset,
  spi_cmd_decoder_if.slave bus
);

  localparam int NB = REG_W / 8;
  localparam int AW = addr_w(NUM_REGS);

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d, addr_inc, cmd_addr, rd_addr, wr_addr_q, wr_addr_d;
  logic [2:0]        cnt_q, cnt_d, cnt_inc, byte_sel;
  logic [REG_W-1:0]  asm_q, asm_d, rd_word, wr_word, rd_shifted;
  logic [REG_W+7:0]  asm_shift;
  logic [7:0]        tx_q, tx_d, rd_byte;
  logic              wr_strobe_q, wr_strobe_d, cmd_err_q, cmd_err_d, busy_q, busy_d;
  logic              cmd_oor, last_byte, commit;

  assign cnt_inc   = cnt_q + 3'd1;
  assign last_byte = (cnt_inc == 3'(NB));
  // Explicit wrap so non-power-of-two banks never index past NUM_REGS-1
  assign addr_inc  = (addr_q == AW'(NUM_REGS - 1)) ? '0 : addr_q + 1'b1;
  assign cmd_addr  = bus.rx_data[AW-1:0];
  assign cmd_oor   = ({1'b0, bus.rx_data[6:0]} >= 8'(NUM_REGS));
  assign asm_shift = {asm_q, bus.rx_data};
  assign wr_word   = asm_shift[REG_W-1:0];
  assign commit    = (state_q == ST_WDATA) && !bus.spi_cs && bus.rx_valid && last_byte;

  always_comb begin
    rd_addr  = addr_q;
    byte_sel = cnt_inc;
    if (state_q == ST_CMD) begin
      rd_addr  = cmd_addr;
      byte_sel = 3'd0;
    end else if (last_byte) begin
      rd_addr  = addr_inc;
      byte_sel = 3'd0;
    end
  end

  assign rd_shifted = rd_word >> (8 * (NB - 1 - int'(byte_sel)));
  assign rd_byte    = rd_shifted[7:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    cmd_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d  = ID_BYTE;
        cnt_d = '0;
        asm_d = '0;
        if (!bus.spi_cs) begin
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (bus.rx_valid) begin
          addr_d = cmd_addr;
          cnt_d  = '0;
          if (cmd_oor) begin
            state_d   = ST_DISCARD;
            cmd_err_d = 1'b1;
            tx_d      = 8'h00;
          end else if (bus.rx_data[CMD_WRITE_BIT]) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_RDATA;
            tx_d    = rd_byte;
          end
        end
      end
      ST_WDATA: begin
        if (bus.rx_valid) begin
          if (last_byte) begin
            cnt_d       = '0;
            asm_d       = '0;
            addr_d      = addr_inc;
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
          end else begin
            cnt_d = cnt_inc;
            asm_d = wr_word;
          end
        end
      end
      ST_RDATA: begin
        if (bus.rx_valid) begin
          tx_d = rd_byte;
          if (last_byte) begin
            cnt_d  = '0;
            addr_d = addr_inc;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_DISCARD: begin
        tx_d = 8'h00;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Deselect wins over any byte arriving in the same cycle
    if (bus.spi_cs && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      addr_d      = addr_q;
      cnt_d       = '0;
      asm_d       = '0;
      tx_d        = ID_BYTE;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      cmd_err_d   = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      tx_q        <= ID_BYTE;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      cmd_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      cmd_err_q   <= cmd_err_d;
      busy_q      <= busy_d;
    end
  end

  spi_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (commit),
    .wr_addr   (addr_q),
    .wr_data   (wr_word),
    .rd_addr   (rd_addr),
    .rd_data   (rd_word),
    .regs_flat (bus.regs)
  );

  assign bus.tx_data   = tx_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
// ============================================================================
// tb_spi_cmd_decoder : directed checks of framing, burst read/write and aborts
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_spi_cmd_decoder;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [255:0] exp_regs;

  spi_cmd_decoder_if #(.NUM_REGS(16), .REG_W(16)) bus ();

  spi_cmd_decoder #(.NUM_REGS(16), .REG_W(16), .ID_BYTE(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one rx_valid strobe from a falling edge; returns on the next falling edge
  task automatic pulse(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic cs_low();
    bus.spi_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_high();
    bus.spi_cs = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    bus.spi_cs   = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    exp_regs     = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 256'(bus.tx_data), 256'hA5);
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_strobe", 256'(bus.wr_strobe), 256'(0));
    check("rst_err", 256'(bus.cmd_err), 256'(0));
    check("rst_wr_addr", 256'(bus.wr_addr), 256'(0));
    check("rst_regs", bus.regs, 256'(0));
    reset = 1'b0;
    @(negedge clk);

    // rx_valid while deselected is ignored
    pulse(8'h83);
    check("idle_rx_busy", 256'(bus.busy), 256'(0));

    // Single write to reg 3
    cs_low();
    check("cmd_busy", 256'(bus.busy), 256'(1));
    pulse(8'h83);
    pulse(8'h12);
    check("w1_no_strobe", 256'(bus.wr_strobe), 256'(0));
    pulse(8'h34);
    exp_regs[3*16 +: 16] = 16'h1234;
    check("w1_strobe", 256'(bus.wr_strobe), 256'(1));
    check("w1_addr", 256'(bus.wr_addr), 256'(3));
    check("w1_regs", bus.regs, exp_regs);
    @(negedge clk);
    check("w1_strobe_low", 256'(bus.wr_strobe), 256'(0));
    cs_high();
    check("w1_idle", 256'(bus.busy), 256'(0));

    // Back-to-back burst write wrapping 15 -> 0
    cs_low();
    pulse(8'h8F);
    pulse(8'hAA);
    pulse(8'hBB);
    exp_regs[15*16 +: 16] = 16'hAABB;
    check("wrap_strobe15", 256'(bus.wr_strobe), 256'(1));
    check("wrap_addr15", 256'(bus.wr_addr), 256'(15));
    check("wrap_regs15", bus.regs, exp_regs);
    pulse(8'hCC);
    check("wrap_mid_strobe", 256'(bus.wr_strobe), 256'(0));
    pulse(8'hDD);
    exp_regs[0 +: 16] = 16'hCCDD;
    check("wrap_strobe0", 256'(bus.wr_strobe), 256'(1));
    check("wrap_addr0", 256'(bus.wr_addr), 256'(0));
    check("wrap_regs0", bus.regs, exp_regs);
    cs_high();

    // Preload regs 2,3 then burst-read them
    cs_low();
    pulse(8'h82);
    pulse(8'hBE);
    pulse(8'hEF);
    pulse(8'h01);
    pulse(8'h02);
    exp_regs[2*16 +: 16] = 16'hBEEF;
    exp_regs[3*16 +: 16] = 16'h0102;
    cs_high();
    check("preload_regs", bus.regs, exp_regs);
    cs_low();
    pulse(8'h02);
    check("rd_b0", 256'(bus.tx_data), 256'hBE);
    pulse(8'h00);
    check("rd_b1", 256'(bus.tx_data), 256'hEF);
    pulse(8'h00);
    check("rd_b2", 256'(bus.tx_data), 256'h01);
    check("rd_no_strobe", 256'(bus.wr_strobe), 256'(0));
    pulse(8'h00);
    check("rd_b3", 256'(bus.tx_data), 256'h02);
    pulse(8'h00);
    check("rd_regs_same", bus.regs, exp_regs);
    cs_high();
    check("rd_tx_id", 256'(bus.tx_data), 256'hA5);

    // Out-of-range command
    cs_low();
    pulse(8'h90);
    check("oor_err", 256'(bus.cmd_err), 256'(1));
    check("oor_tx", 256'(bus.tx_data), 256'h00);
    pulse(8'h55);
    check("oor_err_once", 256'(bus.cmd_err), 256'(0));
    pulse(8'h66);
    check("oor_no_strobe", 256'(bus.wr_strobe), 256'(0));
    check("oor_tx_hold", 256'(bus.tx_data), 256'h00);
    check("oor_regs", bus.regs, exp_regs);
    cs_high();
    check("oor_tx_id", 256'(bus.tx_data), 256'hA5);

    // Abort mid-write, then abort with cs and rx_valid together
    cs_low();
    pulse(8'h85);
    pulse(8'h77);
    cs_high();
    check("abort_busy", 256'(bus.busy), 256'(0));
    check("abort_regs", bus.regs, exp_regs);
    cs_low();
    pulse(8'h85);
    pulse(8'h77);
    bus.spi_cs = 1'b1;
    pulse(8'h88);
    check("abort2_strobe", 256'(bus.wr_strobe), 256'(0));
    check("abort2_busy", 256'(bus.busy), 256'(0));
    check("abort2_regs", bus.regs, exp_regs);
    cs_low();
    pulse(8'h85);
    pulse(8'h11);
    pulse(8'h22);
    exp_regs[5*16 +: 16] = 16'h1122;
    check("post_abort_addr", 256'(bus.wr_addr), 256'(5));
    check("post_abort_regs", bus.regs, exp_regs);
    cs_high();

    // Reset in the middle of a write burst with cs held low
    cs_low();
    pulse(8'h84);
    pulse(8'h01);
    reset = 1'b1;
    @(negedge clk);
    exp_regs = '0;
    check("mrst_regs", bus.regs, exp_regs);
    check("mrst_tx", 256'(bus.tx_data), 256'hA5);
    check("mrst_busy", 256'(bus.busy), 256'(0));
    check("mrst_wr_addr", 256'(bus.wr_addr), 256'(0));
    reset = 1'b0;
    @(negedge clk);
    check("mrst_cmd_busy", 256'(bus.busy), 256'(1));
    pulse(8'h84);
    pulse(8'h56);
    pulse(8'h78);
    exp_regs[4*16 +: 16] = 16'h5678;
    check("mrst_wr_strobe", 256'(bus.wr_strobe), 256'(1));
    check("mrst_wr_regs", bus.regs, exp_regs);
    cs_high();
    check("end_idle", 256'(bus.busy), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
